// File: rtl/chia10_pkg.sv
// Shared definitions for the sequential divide-by-10 block.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   DIVISOR    : constant divisor
//   WIDTH_DEF  : default dividend/quotient width
//   WIDTH_ALT  : alternative supported dividend/quotient width
//   REM_W      : remainder / partial-remainder width
//   T_W        : width of one trial value {pr, dividend bit}
package chia10_pkg;

  localparam int unsigned DIVISOR   = 10;
  localparam int unsigned WIDTH_DEF = 43;
  localparam int unsigned WIDTH_ALT = 28;
  localparam int unsigned REM_W     = 4;
  localparam int unsigned T_W       = REM_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chia10_step.sv
// One restoring division step by 10 (purely combinational).
//   pr_in    : partial remainder before the step (always 0..9)
//   bit_in   : next dividend bit, MSB first
//   pr_out_c : partial remainder after the step (0..9)
//   qbit_c   : quotient bit produced by this step
module chia10_step
  import chia10_pkg::*;
(
  input  logic [REM_W-1:0] pr_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] pr_out_c,
  output logic             qbit_c
);

  logic [T_W-1:0] t;

  // Since pr_in <= 9, t <= 19, so a single conditional subtract is enough.
  always_comb begin
    t        = {pr_in, bit_in};
    pr_out_c = REM_W'(t);
    qbit_c   = 1'b0;
    if (t >= T_W'(DIVISOR)) begin
      pr_out_c = REM_W'(t - T_W'(DIVISOR));
      qbit_c   = 1'b1;
    end
  end

endmodule

// File: rtl/chia10_seq.sv
// Sequential restoring divider by 10, one quotient bit per clock, MSB first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request, sampled only in IDLE
//   din   : dividend, captured on the accepted start edge
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when quo/rem/zero become valid
//   quo   : din / 10, held until the next completed operation
//   rem   : din % 10
//   zero  : quo == 0, updated together with quo
module chia10_seq
  import chia10_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [REM_W-1:0] rem,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sr;
  logic [REM_W-1:0] pr;
  logic [CNT_W-1:0] cnt;

  logic [REM_W-1:0] pr_step_c;
  logic             qbit_c;
  logic [WIDTH-1:0] sr_step_c;
  logic             last_step_c;
  logic             busy_nxt_c;
  logic             done_nxt_c;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after WIDTH steps the working register holds the full quotient.
  chia10_step u_step (
    .pr_in    (pr),
    .bit_in   (sr[WIDTH-1]),
    .pr_out_c (pr_step_c),
    .qbit_c   (qbit_c)
  );

  assign sr_step_c   = {sr[WIDTH-2:0], qbit_c};
  assign last_step_c = (cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_step_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done register in step with state.
  always_comb begin
    busy_nxt_c = 1'b0;
    done_nxt_c = 1'b0;
    case (next_state)
      RUN:     busy_nxt_c = 1'b1;
      DONE: begin
        busy_nxt_c = 1'b1;
        done_nxt_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sr   <= '0;
      pr   <= '0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      zero <= 1'b1;
    end else begin
      busy <= busy_nxt_c;
      done <= done_nxt_c;
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= din;
            pr  <= '0;
            cnt <= CNT_W'(WIDTH - 1);
          end
        end
        RUN: begin
          sr <= sr_step_c;
          pr <= pr_step_c;
          if (last_step_c) begin
            quo  <= sr_step_c;
            rem  <= pr_step_c;
            zero <= (sr_step_c == '0);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chia10_seq.sv
// Self-checking bench for chia10_seq at WIDTH = 43 and WIDTH = 28.
module tb_chia10_seq;

  localparam int W43  = 43;
  localparam int W28  = 28;
  localparam int P43  = W43 + 2;
  localparam int P28  = W28 + 2;
  localparam int NCYC = 600 * P43;

  typedef struct {
    logic [42:0] din;
    logic [42:0] quo;
    logic [3:0]  rem;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [42:0] din;
  logic        busy, done, zero;
  logic [42:0] quo;
  logic [3:0]  rem;

  logic        start28;
  logic [27:0] din28;
  logic        busy28, done28, zero28;
  logic [27:0] quo28;
  logic [3:0]  rem28;

  int total = 0;
  int bad   = 0;
  int pr_bad = 0;

  always #5 clk = ~clk;

  chia10_seq #(.WIDTH(W43)) dut43 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .zero(zero)
  );

  chia10_seq #(.WIDTH(W28)) dut28 (
    .clk(clk), .rst_n(rst_n), .start(start28), .din(din28),
    .busy(busy28), .done(done28), .quo(quo28), .rem(rem28), .zero(zero28)
  );

  // Partial remainder must stay within 0..9 after every step.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dut43.pr > 4'd9) pr_bad++;
      if (dut28.pr > 4'd9) pr_bad++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation on the 43-bit instance with latency, hold and pulse checks.
  task automatic op43(input vec_t v, input logic [42:0] prev_q, input string tag);
    int lat;
    int hold_err;
    hold_err = 0;
    din   = v.din;
    start = 1'b1;
    tick;
    start = 1'b0;
    din   = ~v.din;
    lat   = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (quo !== prev_q) hold_err++;
      tick;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(W43 + 1));
    check({tag, ".quo"}, 64'(quo), 64'(v.quo));
    check({tag, ".rem"}, 64'(rem), 64'(v.rem));
    check({tag, ".zero"}, 64'(zero), 64'(v.zero));
    check({tag, ".hold"}, 64'(hold_err), 64'd0);
    tick;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  vec_t        tbl[5];
  vec_t        v;
  logic [42:0] prev_q;
  logic [42:0] q43[$];
  logic [27:0] q28[$];
  logic [63:0] dd;
  int          lat, ndone, t_err43, t_err28, ops43, ops28, exp_ops43, exp_ops28;
  bit          exp_d43, exp_d28;

  initial begin
    tbl[0] = '{din: 43'd12345,         quo: 43'd1234,         rem: 4'd5, zero: 1'b0};
    tbl[1] = '{din: 43'd0,             quo: 43'd0,            rem: 4'd0, zero: 1'b1};
    tbl[2] = '{din: 43'd9,             quo: 43'd0,            rem: 4'd9, zero: 1'b1};
    tbl[3] = '{din: 43'd10,            quo: 43'd1,            rem: 4'd0, zero: 1'b0};
    tbl[4] = '{din: 43'd8796093022207, quo: 43'd879609302220, rem: 4'd7, zero: 1'b0};

    rst_n = 1'b0; start = 1'b0; din = '0; start28 = 1'b0; din28 = '0;
    tick; tick;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.quo",  64'(quo),  64'd0);
    check("reset.rem",  64'(rem),  64'd0);
    check("reset.zero", 64'(zero), 64'd1);
    check("reset28.zero", 64'(zero28), 64'd1);
    rst_n = 1'b1;
    tick;

    // Back-to-back table of edge values.
    prev_q = '0;
    for (int i = 0; i < 5; i++) begin
      op43(tbl[i], prev_q, $sformatf("vec%0d", i));
      prev_q = tbl[i].quo;
    end

    // Starts and din changes during RUN are ignored.
    din = 43'd100; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1; din = 43'd12345;
      end else begin
        start = 1'b0; din = 43'd555;
      end
      tick;
      lat++;
    end
    start = 1'b0;
    check("busyrej.latency", 64'(lat), 64'(W43 + 1));
    check("busyrej.quo", 64'(quo), 64'd10);
    check("busyrej.rem", 64'(rem), 64'd0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    check("busyrej.extra_done", 64'(ndone), 64'd0);
    check("busyrej.idle", 64'(busy), 64'd0);

    // Reset in the middle of an operation.
    din = 43'd12345; start = 1'b1;
    tick;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.quo",  64'(quo),  64'd0);
    check("midrst.rem",  64'(rem),  64'd0);
    check("midrst.zero", 64'(zero), 64'd1);
    check("midrst.no_done", 64'(ndone), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    v = '{din: 43'd77, quo: 43'd7, rem: 4'd7, zero: 1'b0};
    op43(v, 43'd0, "after_rst");

    // Continuous start with random dividends on both widths.
    t_err43 = 0; t_err28 = 0; ops43 = 0; ops28 = 0; exp_ops43 = 0; exp_ops28 = 0;
    din = '1; din28 = '1;
    start = 1'b1; start28 = 1'b1;
    for (int e = 0; e < NCYC; e++) begin
      if (e % P43 == 0) q43.push_back(din);
      if (e % P28 == 0) q28.push_back(din28);
      tick;
      exp_d43 = (e % P43 == W43);
      exp_d28 = (e % P28 == W28);
      if (done !== exp_d43) t_err43++;
      if (done28 !== exp_d28) t_err28++;
      if (exp_d43) begin
        exp_ops43++;
        if (q43.size() > 0) begin
          ops43++;
          dd = 64'(q43.pop_front());
          check("rnd43.quo", 64'(quo), dd / 10);
          check("rnd43.rem", 64'(rem), dd % 10);
          check("rnd43.recompose", 64'(quo) * 10 + 64'(rem), dd);
          check("rnd43.rem_range", 64'(rem < 4'd10), 64'd1);
        end
      end
      if (exp_d28) begin
        exp_ops28++;
        if (q28.size() > 0) begin
          ops28++;
          dd = 64'(q28.pop_front());
          check("rnd28.quo", 64'(quo28), dd / 10);
          check("rnd28.rem", 64'(rem28), dd % 10);
          check("rnd28.recompose", 64'(quo28) * 10 + 64'(rem28), dd);
          check("rnd28.rem_range", 64'(rem28 < 4'd10), 64'd1);
        end
      end
      din   = 43'({$urandom(), $urandom()});
      din28 = 28'($urandom());
      if ($urandom_range(0, 7) == 0) din   = 43'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) din28 = 28'($urandom_range(0, 20));
    end
    start = 1'b0; start28 = 1'b0;
    check("rnd43.done_timing", 64'(t_err43), 64'd0);
    check("rnd28.done_timing", 64'(t_err28), 64'd0);
    check("rnd43.ops", 64'(ops43), 64'(exp_ops43));
    check("rnd28.ops", 64'(ops28), 64'(exp_ops28));
    tick; tick;
    check("pr_invariant", 64'(pr_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
